// File: rtl/gpio_db_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_db_pkg
//  Description : Shared constants and types for the slide-switch debouncer.
//  Revision    : 1.0  initial release
// ============================================================================
package gpio_db_pkg;

    // 10 ms of stability at the 50 MHz core clock
    localparam int DB_CYCLES_DEFAULT = 500000;

    // Slide switches on the Nexys A7
    localparam int N_SW_NEXYS = 16;

    typedef logic [N_SW_NEXYS-1:0] sw_vec_t;

endpackage : gpio_db_pkg
`default_nettype wire

// File: rtl/gpio_db_chan.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_db_chan
//  Description : One switch channel: 2-FF synchroniser, stability counter,
//                debounced level, rise/fall pulses and an optional sticky
//                change flag (built when GPIO_DB_EVENT_EN is defined).
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_db_chan #(
    parameter int   DB_CYCLES = 4,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    input  logic evt_clr_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o,
    output logic evt_o
);

    localparam int               CNT_W      = $clog2(DB_CYCLES + 1);
    // Count reached on the last of DB_CYCLES consecutive differing cycles
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Two-flop synchroniser bringing the raw pin into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
        end
    end

    // Qualification: count while the synchronised input differs from the
    // accepted level; any agreeing cycle drops back to idle (count 0)
    always_comb begin
        cnt_d  = '0;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync2_q != lvl_q) begin
            if (cnt_q == c_cnt_last) begin
                lvl_d  = sync2_q;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter, accepted level and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            lvl_q  <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_o   = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef GPIO_DB_EVENT_EN
    logic evt_q, evt_d;

    // Sticky change flag: a pulse sets it, a clear request drops it, and a
    // pulse arriving together with a clear keeps it set
    always_comb begin
        evt_d = (evt_q & ~evt_clr_i) | rise_q | fall_q;
    end

    // Sticky flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_o = evt_q;
`else
    // Feature absent: flag tied low, clear request intentionally unused
    logic w_unused_clr;
    assign w_unused_clr = evt_clr_i;
    assign evt_o        = 1'b0;
`endif

endmodule : gpio_db_chan
`default_nettype wire

// File: rtl/gpio_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_sw_debounce
//  Description : Synchronises and debounces N_CH asynchronous slide switches
//                for the SoC GPIO input bus. Provides the clean level plus
//                one-cycle rise/fall pulses per channel. Optional sticky
//                change flags are enabled with the GPIO_DB_EVENT_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_sw_debounce
    import gpio_db_pkg::*;
#(
    parameter int              N_CH      = N_SW_NEXYS,
    parameter int              DB_CYCLES = DB_CYCLES_DEFAULT, // must be >= 1
    parameter logic [N_CH-1:0] RESET_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sw_i,
    output logic [N_CH-1:0] sw_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] evt_o,
    input  logic [N_CH-1:0] evt_clr_i
);

    // One fully independent debouncer per switch
    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        gpio_db_chan #(
            .DB_CYCLES (DB_CYCLES),
            .RESET_VAL (RESET_VAL[g])
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .sw_i      (sw_i[g]),
            .evt_clr_i (evt_clr_i[g]),
            .sw_o      (sw_o[g]),
            .rise_o    (rise_o[g]),
            .fall_o    (fall_o[g]),
            .evt_o     (evt_o[g])
        );
    end

endmodule : gpio_sw_debounce
`default_nettype wire

// File: tb/tb_gpio_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpio_sw_debounce
//  Description : Self-checking bench for gpio_sw_debounce (N_CH=16,
//                DB_CYCLES=4, RESET_VAL=0). A window-based reference model
//                predicts every output each cycle; directed scenarios add
//                explicit latency, glitch, reset and sticky-flag checks.
//                Build with GPIO_DB_EVENT_EN to exercise the sticky flags.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpio_sw_debounce;

    localparam int          N_CH    = 16;
    localparam int          DB      = 4;
    localparam logic [15:0] RST_VAL = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_i;
    logic [15:0] evt_clr_i;
    logic [15:0] sw_o;
    logic [15:0] rise_o;
    logic [15:0] fall_o;
    logic [15:0] evt_o;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    gpio_sw_debounce #(
        .N_CH      (N_CH),
        .DB_CYCLES (DB),
        .RESET_VAL (RST_VAL)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_i      (sw_i),
        .sw_o      (sw_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .evt_o     (evt_o),
        .evt_clr_i (evt_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. The level of a channel flips once the last DB
    // synchronised samples observed since reset all disagree with it.
    // Synchronised sample seen at an edge = sw_i captured two edges back.
    // ------------------------------------------------------------------
    logic [15:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_evt;
    logic [15:0] hist[$];

    always @(posedge clk or negedge rst_n) begin
        logic [15:0] seen;
        bit          all_diff;
        if (!rst_n) begin
            m_s1   = '0;
            m_s2   = '0;
            m_lvl  = RST_VAL;
            m_rise = '0;
            m_fall = '0;
            m_evt  = '0;
            hist.delete();
        end else begin
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = sw_i;
`ifdef GPIO_DB_EVENT_EN
            m_evt = (m_evt & ~evt_clr_i) | m_rise | m_fall;
`endif
            hist.push_back(seen);
            if (hist.size() > DB) void'(hist.pop_front());
            m_rise = '0;
            m_fall = '0;
            if (hist.size() == DB) begin
                for (int c = 0; c < N_CH; c++) begin
                    all_diff = 1'b1;
                    foreach (hist[j]) if (hist[j][c] == m_lvl[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_lvl[c] = ~m_lvl[c];
                        if (m_lvl[c]) m_rise[c] = 1'b1;
                        else          m_fall[c] = 1'b1;
                    end
                end
            end
        end
    end

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("lvl",     sw_o,            m_lvl);
            chk("rise",    rise_o,          m_rise);
            chk("fall",    fall_o,          m_fall);
            chk("evt",     evt_o,           m_evt);
            chk("rf_excl", rise_o & fall_o, 16'h0000);
        end
    end

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] mask;

    initial begin
        rst_n     = 1'b0;
        sw_i      = 16'h0000;
        evt_clr_i = 16'h0000;
        tick(3);
        chk_en = 1'b1;
        chk("rst_sw", sw_o, 16'h0000);
        chk("rst_pulse", rise_o | fall_o, 16'h0000);
        rst_n = 1'b1;

        // Quiet inputs: nothing may move for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("quiet_sw", sw_o, 16'h0000);
            chk("quiet_pulse", rise_o | fall_o, 16'h0000);
        end

        // Clean step on ch3, launched right after edge k: accepted at k+6
        sw_i[3] = 1'b1;
        tick(5);
        chk("ch3_k5", sw_o, 16'h0000);
        tick(1);
        chk("ch3_k6_sw", sw_o, 16'h0008);
        chk("ch3_k6_rise", rise_o, 16'h0008);
        tick(1);
        chk("ch3_k7_rise", rise_o, 16'h0000);

        // 3-cycle glitch on ch5 is rejected
        sw_i[5] = 1'b1;
        tick(3);
        sw_i[5] = 1'b0;
        tick(10);
        chk("ch5_glitch", sw_o, 16'h0008);

        // 4-cycle pulse on ch5 is accepted, then falls back
        sw_i[5] = 1'b1;
        tick(4);
        sw_i[5] = 1'b0;
        tick(2);
        chk("ch5_acc_sw", sw_o, 16'h0028);
        chk("ch5_acc_rise", rise_o, 16'h0020);
        tick(8);
        chk("ch5_back", sw_o, 16'h0008);

        // All channels step together
        sw_i = 16'hFFFF;
        tick(6);
        chk("all_rise", rise_o, 16'hFFF7);
        tick(3);
        sw_i = 16'h0000;
        tick(6);
        chk("all_fall", fall_o, 16'hFFFF);
        chk("all_fall_sw", sw_o, 16'h0000);
        tick(4);

        // Reset during qualification on ch0 (counter at 2)
        sw_i[0] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        chk("midrst_sw", sw_o, 16'h0000);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        chk("rel_k5", sw_o, 16'h0000);
        chk("rel_k5_rise", rise_o, 16'h0000);
        tick(1);
        chk("rel_k6_sw", sw_o, 16'h0001);
        chk("rel_k6_rise", rise_o, 16'h0001);

        // Sticky flag: fall on ch7 with clear on the pulse cycle
        sw_i[7] = 1'b1;
        tick(10);
        evt_clr_i = 16'hFFFF;
        tick(1);
        evt_clr_i = 16'h0000;
        sw_i[7] = 1'b0;
        tick(6);
        chk("ch7_fall", fall_o, 16'h0080);
        evt_clr_i[7] = 1'b1;
        tick(1);
`ifdef GPIO_DB_EVENT_EN
        chk("ch7_setwins", evt_o, 16'h0080);
`else
        chk("ch7_evt_off", evt_o, 16'h0000);
`endif
        tick(1);
        chk("ch7_cleared", evt_o, 16'h0000);
        evt_clr_i = 16'h0000;

        // Randomised stretch, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            mask = 16'h0000;
            for (int b = 0; b < N_CH; b++) if ($urandom_range(7) == 0) mask[b] = 1'b1;
            sw_i      = sw_i ^ mask;
            evt_clr_i = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(249) == 0) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            tick(1);
        end

        tick(2);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gpio_sw_debounce
`default_nettype wire
